// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Accepts execute-stage results and waits for load
// data when needed. Each result is committed to the register file for one
// cycle. A load that gets no data within TIMEOUT wait cycles is dropped and
// err_timeout pulses for one cycle.
// Optional feature macro: WB_FWD_EN adds decode-stage forwarding hit/data ports.
module wb_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_sel,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc4,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        err_timeout
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd_data
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  // The counter holds the number of wait cycles already spent. The wait cycle
  // seen with the counter at TIMEOUT-1 is therefore the TIMEOUT-th one.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [4:0]  rd_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [31:0] wd_reg;
  logic [7:0]  cnt_reg;
  logic        err_reg;

  logic        accept;
  logic        load_done;
  logic        timeout_hit;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign in_ready    = (state_reg != WAIT_MEM);
  assign accept      = in_valid && in_ready;
  assign load_done   = (state_reg == WAIT_MEM) && mem_rvalid;
  // Data arriving on the last allowed cycle has priority over the timeout.
  assign timeout_hit = (state_reg == WAIT_MEM) && !mem_rvalid && (cnt_reg == CNT_LAST);

  assign rf_we       = (state_reg == COMMIT) && we_reg && (rd_reg != 5'd0);
  assign rf_wa       = rd_reg;
  assign rf_wd       = wd_reg;
  assign err_timeout = err_reg;

  // State register; reset abandons any pending load or commit.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: loads go through WAIT_MEM, everything else commits next cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, COMMIT: begin
        if (accept) state_next = (in_sel == 2'd1) ? WAIT_MEM : COMMIT;
        else        state_next = IDLE;
      end
      WAIT_MEM: begin
        if (load_done)        state_next = COMMIT;
        else if (timeout_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load extraction: pick the byte/halfword at the latched address offset.
  always_comb begin
    load_byte = 8'h00;
    load_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (off_reg)
      2'd0: load_byte = mem_rdata[7:0];
      2'd1: load_byte = mem_rdata[15:8];
      2'd2: load_byte = mem_rdata[23:16];
      2'd3: load_byte = mem_rdata[31:24];
      default: load_byte = mem_rdata[7:0];
    endcase
    case (funct3_reg)
      3'b000: load_data = {{24{load_byte[7]}}, load_byte};
      3'b100: load_data = {24'h000000, load_byte};
      3'b001: load_data = {{16{load_half[15]}}, load_half};
      3'b101: load_data = {16'h0000, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Result registers: capture on accept, overwrite data when load data arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      rd_reg     <= 5'd0;
      funct3_reg <= 3'd0;
      off_reg    <= 2'd0;
      wd_reg     <= 32'd0;
    end else if (accept) begin
      we_reg     <= in_we;
      rd_reg     <= in_rd;
      funct3_reg <= in_funct3;
      off_reg    <= in_alu[1:0];
      wd_reg     <= (in_sel == 2'd2) ? in_pc4 : in_alu;
    end else if (load_done) begin
      wd_reg     <= load_data;
    end
  end

  // Wait-cycle counter and one-cycle timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= 8'd0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= timeout_hit;
      if ((state_reg == WAIT_MEM) && !load_done && !timeout_hit) cnt_reg <= cnt_reg + 8'd1;
      else                                                       cnt_reg <= 8'd0;
    end
  end

`ifdef WB_FWD_EN
  assign fwd1_hit = rf_we && (rf_wa == dec_rs1);
  assign fwd2_hit = rf_we && (rf_wa == dec_rs2);
  assign fwd_data = rf_wd;
`endif

endmodule
